serial_sub_ctrl: RTL and testbench

Bit-serial N-bit subtractor controller. It sequences a single 1-bit full-subtractor cell across WIDTH operand bits, LSB first, carrying the borrow in a register between cycles. It trades latency for area and serves as the shared subtraction resource in the arithmetic datapath. Operands are captured by a start/busy/done handshake, and registered results are held until the next operation completes.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/bit_sub_cell.sv | 13 +
 rtl/serial_sub_ctrl.sv | 97 +++++++++
 tb/tb_serial_sub_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the serial subtractor
//   ST_IDLE/ST_RUN/ST_DONE - controller state codes
//   SUB_W                  - default operand width
//   state_t                - controller state type
package serial_sub_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int SUB_W = 8;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/bit_sub_cell.sv
// bit_sub_cell: combinational 1-bit full subtractor computing x - y - bi
//   x, y, bi - minuend bit, subtrahend bit, borrow in
//   d, bo    - difference bit, borrow out
module bit_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & (y ^ bi)) | (y & bi);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor, LSB first, one cell reused per cycle
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   start, a, b, bin  - request and operands, captured on the accept edge
//   busy, done        - high while running / one-cycle completion pulse
//   diff, bout, ovf   - a - b - bin, unsigned borrow out, signed overflow (held until next done)
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sd;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_sd_next;

    bit_sub_cell u_cell (
        .x  (r_sa[0]),
        .y  (r_sb[0]),
        .bi (r_br),
        .d  (w_d),
        .bo (w_bo)
    );

    // each new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
    assign w_sd_next = {w_d, r_sd[WIDTH-1:1]};
    assign w_last    = r_cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sd    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                // the DONE exit edge also samples start, giving back-to-back operation
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_sd  <= w_sd_next;
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        diff    <= w_sd_next;
                        bout    <= w_bo;
                        // borrow into the MSB differs from borrow out of it on signed overflow
                        ovf     <= w_bo ^ r_br;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench for serial_sub_ctrl with an arithmetic reference model
module tb_serial_sub_ctrl;
    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    exp_t       sb[$];
    int         pcnt = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] held_d = '0;
    logic       held_bo = 1'b0;
    logic       held_ov = 1'b0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, pcnt);
        end
    endtask

    // reference: plain wide arithmetic on unsigned and signed views of the operands
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic bi);
        logic [8:0] t;
        int sx, sy, s;
        t  = {1'b0, x} - {1'b0, y} - {8'd0, bi};
        sx = $signed(x);
        sy = $signed(y);
        s  = sx - sy - int'(bi);
        a = x;
        b = y;
        bin = bi;
        start = 1'b1;
        sb.push_back('{t[7:0], t[8], (s < -128 || s > 127), pcnt + 9});
    endtask

    task automatic single(input logic [7:0] x, input logic [7:0] y, input logic bi);
        @(negedge clk);
        issue(x, y, bi);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        bin = 1'($urandom);
        repeat (8) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic ebusy, edone;
        edone = sb.size() > 0 && sb[0].at == pcnt;
        ebusy = sb.size() > 0 && pcnt >= sb[0].at - 8 && pcnt < sb[0].at;
        if (edone) begin
            held_d  = sb[0].d;
            held_bo = sb[0].bo;
            held_ov = sb[0].ov;
            void'(sb.pop_front());
        end
        chk("busy", 32'(busy), 32'(ebusy));
        chk("done", 32'(done), 32'(edone));
        chk("diff", 32'(diff), 32'(held_d));
        chk("bout", 32'(bout), 32'(held_bo));
        chk("ovf", 32'(ovf), 32'(held_ov));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        single(8'h5A, 8'h3C, 1'b0);
        single(8'h00, 8'h01, 1'b0);
        single(8'h10, 8'h0F, 1'b1);
        single(8'h80, 8'h01, 1'b0);
        single(8'h7F, 8'hFF, 1'b0);
        // starts during RUN must be ignored
        @(negedge clk);
        issue(8'h33, 8'h11, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h01; b = 8'hFE; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // start held high: one accept every 9 cycles
        @(negedge clk);
        issue(8'($urandom), 8'($urandom), 1'($urandom));
        repeat (5) begin
            repeat (9) @(negedge clk);
            issue(8'($urandom), 8'($urandom), 1'($urandom));
        end
        repeat (9) @(negedge clk);
        start = 1'b0;
        // asynchronous reset in the middle of RUN cycle 4
        @(negedge clk);
        issue(8'hC3, 8'h5A, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        held_d = '0;
        held_bo = 1'b0;
        held_ov = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        repeat (24) begin
            single(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
